// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, issue entry layout and FSM states for the MIPS issue path
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int OREG_W = 20;
  typedef struct packed {
    logic [OREG_W-1:0]  oreg;
    logic [INSTR_W-1:0] instr;
  } issue_entry_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issue_state_t;
endpackage

// File: rtl/mips_issue_queue_if.sv
// mips_issue_queue_if: host stream and core handshake bundle of the issue queue
interface mips_issue_queue_if;
  logic                         host_valid;
  logic [mips_pkg::INSTR_W-1:0] host_instr;
  logic [mips_pkg::OREG_W-1:0]  host_oreg;
  logic                         host_ready;
  logic                         core_in_valid;
  logic [mips_pkg::INSTR_W-1:0] core_instr;
  logic [mips_pkg::OREG_W-1:0]  core_oreg;
  logic                         core_out_valid;
  logic                         core_fail;
  modport slave (
    input  host_valid, host_instr, host_oreg, core_out_valid, core_fail,
    output host_ready, core_in_valid, core_instr, core_oreg
  );
  modport master (
    output host_valid, host_instr, host_oreg, core_out_valid, core_fail,
    input  host_ready, core_in_valid, core_instr, core_oreg
  );
endinterface

// File: rtl/mips_issue_fifo.sv
// mips_issue_fifo: sync FIFO of issue entries; flush wins over push and pop
module mips_issue_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  issue_entry_t din,
  output issue_entry_t dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  issue_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mips_issue_queue.sv
// mips_issue_queue: buffers host instructions and issues them one at a time to the MIPS core,
// with saturating issue/fail statistics and a watchdog on unresponsive completions
module mips_issue_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int WD_W = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mips_issue_queue_if.slave io,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_timeout
);
  issue_state_t state;
  issue_entry_t din, head;
  logic [AW:0] fifo_cnt;
  logic [WD_W-1:0] wd;
  logic full, empty, pop;
  assign din = '{oreg: io.host_oreg, instr: io.host_instr};
  assign io.host_ready = !full;
  assign pop = state == IDLE && !empty && !flush;
  assign busy = state != IDLE;
  mips_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(io.host_valid),
    .pop(pop),
    .flush(flush),
    .din(din),
    .dout(head),
    .count(fifo_cnt),
    .full(full),
    .empty(empty)
  );
  assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt <= (AW+1)'(DEPTH));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wd <= '0;
      io.core_in_valid <= 1'b0;
      io.core_instr <= '0;
      io.core_oreg <= '0;
      issue_cnt <= '0;
      fail_cnt <= '0;
      err_timeout <= 1'b0;
    end else
      case (state)
        IDLE:
          if (pop) begin
            io.core_instr <= head.instr;
            io.core_oreg <= head.oreg;
            io.core_in_valid <= 1'b1;
            state <= ISSUE;
          end
        ISSUE: begin
          io.core_in_valid <= 1'b0;
          issue_cnt <= issue_cnt + CNT_W'(issue_cnt != '1);
          wd <= '0;
          state <= WAIT;
        end
        WAIT:
          if (io.core_out_valid) begin
            fail_cnt <= fail_cnt + CNT_W'(io.core_fail && fail_cnt != '1);
            state <= IDLE;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state <= IDLE;
          end else
            wd <= wd + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mips_issue_queue.sv
// tb_mips_issue_queue: directed checks of issue latency, ordering, backpressure, stats, watchdog, flush and reset
module tb_mips_issue_queue;
  logic clk, rst_n, flush, busy, err_timeout;
  logic [15:0] issue_cnt, fail_cnt;
  int errors = 0, checks = 0;
  logic [31:0] exp_i [$];
  logic [19:0] exp_o [$];
  mips_issue_queue_if bus ();
  mips_issue_queue dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .io(bus),
    .busy(busy),
    .issue_cnt(issue_cnt),
    .fail_cnt(fail_cnt),
    .err_timeout(err_timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [31:0] i, input logic [19:0] o);
    int n = 0;
    while (!bus.host_ready && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) check("host_ready_wait", n, 0);
    bus.host_valid = 1'b1;
    bus.host_instr = i;
    bus.host_oreg = o;
    tick();
    bus.host_valid = 1'b0;
    exp_i.push_back(i);
    exp_o.push_back(o);
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (!bus.core_in_valid && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) check("issue_wait", n, 0);
  endtask

  task automatic complete(input logic f);
    bus.core_out_valid = 1'b1;
    bus.core_fail = f;
    tick();
    bus.core_out_valid = 1'b0;
    bus.core_fail = 1'b0;
  endtask

  task automatic serve(input int cnt, input int fail_idx, input int dly);
    int n;
    logic [31:0] ei;
    for (int k = 0; k < cnt; k++) begin
      wait_issue(n);
      if (k > 0) check("issue_gap", n, 1);
      ei = exp_i.pop_front();
      check("issue_instr", bus.core_instr, ei);
      check("issue_oreg", bus.core_oreg, exp_o.pop_front());
      tick();
      check("pulse_width", bus.core_in_valid, 0);
      tick(dly);
      check("instr_hold", bus.core_instr, ei);
      complete(k == fail_idx);
    end
  endtask

  task automatic quiet(input string tag, input int cyc);
    int seen = 0;
    for (int k = 0; k < cyc; k++) begin
      tick();
      if (bus.core_in_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int n, m;
    rst_n = 1'b1;
    flush = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_instr = '0;
    bus.host_oreg = '0;
    bus.core_out_valid = 1'b0;
    bus.core_fail = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", bus.host_ready, 1);
    check("rst_in_valid", bus.core_in_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_instr", bus.core_instr, 0);
    check("rst_cnts", {issue_cnt, fail_cnt}, 0);
    check("rst_err", err_timeout, 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    // single instruction: issue pulse lands two cycles after the push edge
    put(32'h0232_4020, 20'h00000);
    check("lat_early", bus.core_in_valid, 0);
    tick();
    check("lat_issue", bus.core_in_valid, 1);
    check("t1_instr", bus.core_instr, exp_i.pop_front());
    check("t1_oreg", bus.core_oreg, exp_o.pop_front());
    tick();
    check("t1_pulse", bus.core_in_valid, 0);
    check("t1_busy", busy, 1);
    tick(2);
    complete(1'b0);
    check("t1_issue_cnt", issue_cnt, 1);
    check("t1_fail_cnt", fail_cnt, 0);
    check("t1_idle", busy, 0);
    // ten pushes against a slow core: backpressure at 8 queued, FIFO order kept
    fork
      for (int i = 0; i < 10; i++) begin
        put(32'h1000_0000 + i, 20'(i * 3 + 1));
        if (i == 8) check("full_ready", bus.host_ready, 0);
      end
      serve(10, -1, 12);
    join
    check("t2_issue_cnt", issue_cnt, 11);
    check("t2_idle", busy, 0);
    // failure on the second of three
    fork
      for (int i = 0; i < 3; i++) put(32'h2000_0000 + i, 20'hA0000 + 20'(i));
      serve(3, 1, 3);
    join
    check("t3_fail_cnt", fail_cnt, 1);
    check("t3_issue_cnt", issue_cnt, 14);
    check("t4_err_pre", err_timeout, 0);
    // silent core: watchdog aborts, next entry still issues
    fork
      begin
        put(32'h3000_0000, 20'h11111);
        put(32'h3000_0001, 20'h22222);
      end
      begin
        wait_issue(n);
        check("t4_instr0", bus.core_instr, exp_i.pop_front());
        void'(exp_o.pop_front());
        m = 0;
        while (!err_timeout && m < 200) begin
          tick();
          m++;
        end
        check("wd_latency", m, 65);
        check("wd_idle", busy, 0);
        wait_issue(n);
        check("wd_reissue_gap", n, 1);
        check("t4_instr1", bus.core_instr, exp_i.pop_front());
        void'(exp_o.pop_front());
        tick(4);
        check("err_sticky", err_timeout, 1);
        complete(1'b0);
      end
    join
    check("t4_issue_cnt", issue_cnt, 16);
    // flush with five queued, one in flight, and a same-cycle push
    fork
      for (int i = 0; i < 6; i++) put(32'h4000_0000 + i, 20'(i));
      wait_issue(n);
    join
    flush = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_instr = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0;
    bus.host_valid = 1'b0;
    exp_i.delete();
    exp_o.delete();
    check("flush_count", dut.u_fifo.count, 0);
    check("flush_busy", busy, 1);
    check("flush_hold", bus.core_instr, 32'h4000_0000);
    complete(1'b1);
    check("flush_fail_cnt", fail_cnt, 2);
    check("flush_issue_cnt", issue_cnt, 17);
    quiet("flush_no_issue", 10);
    // asynchronous reset in WAIT with three queued
    fork
      for (int i = 0; i < 4; i++) put(32'h5000_0000 + i, 20'(i));
      wait_issue(n);
    join
    exp_i.delete();
    exp_o.delete();
    tick(2);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_valid", bus.core_in_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_instr", bus.core_instr, 0);
    check("arst_oreg", bus.core_oreg, 0);
    check("arst_cnts", {issue_cnt, fail_cnt}, 0);
    check("arst_err", err_timeout, 0);
    check("arst_ready", bus.host_ready, 1);
    tick();
    rst_n = 1'b1;
    quiet("post_rst_no_issue", 10);
    check("post_rst_ready", bus.host_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_issue_queue.md
Name: mips_issue_queue

Overview:
Upstream issue stage for the MIPS execution core. It buffers {output_reg, instruction} pairs from a host stream in a small FIFO and feeds the core one instruction at a time. Each in_valid is a single-cycle pulse, and the next instruction is issued only after the core signals completion. It also keeps issue and fail statistics and a watchdog for a core that never responds.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT, 64, max cycles in WAIT without core_out_valid before abort.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  sync clear of FIFO contents; does not abort an in-flight instruction
host_valid  in  1  host entry valid
host_instr  in  32  instruction word
host_oreg  in  20  output-register selector, four 5-bit fields
host_ready  out  1  FIFO can accept
core_in_valid  out  1  one-cycle issue pulse to core in_valid
core_instr  out  32  to core instruction; held stable from issue until completion
core_oreg  out  20  to core output_reg; same holding rule as core_instr
core_out_valid  in  1  core completion
core_fail  in  1  core instruction_fail; sampled with core_out_valid
busy  out  1  high in ISSUE or WAIT
issue_cnt  out  CNT_W  instructions issued, saturating
fail_cnt  out  CNT_W  completions with core_fail=1, saturating
err_timeout  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset state: asynchronous, active-low reset rst_n; clock clk. On reset, FIFO empty, FSM IDLE, core_in_valid/busy/err_timeout=0, core_instr/core_oreg=0, counters=0. host_ready=1 after reset.
- FIFO:
  - push = host_valid && host_ready.
  - host_ready = (count != DEPTH), decoded from registered count only. A pop in the same cycle does not free space for a push when full.
  - Pointers wrap modulo DEPTH.
  - count is DEPTH_W+1 bits wide and never over- or underflows.
  - flush empties the FIFO (pointers and count to 0) and wins over a same-cycle push or pop. The current core_instr/core_oreg and FSM state are untouched.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if FIFO is not empty and flush=0, then on the edge:
    - pop the head;
    - load core_instr/core_oreg;
    - set core_in_valid=1;
    - go to ISSUE.
  - ISSUE: lasts exactly 1 cycle. core_in_valid drops to 0 on exit, issue_cnt increments, and the FSM moves to WAIT with the watchdog cleared.
  - WAIT: the watchdog increments each cycle.
    - On core_out_valid: fail_cnt increments if core_fail=1, then go to IDLE.
    - If the watchdog reaches TIMEOUT-1 without core_out_valid: set err_timeout and go to IDLE.
    - core_out_valid in IDLE or ISSUE is ignored and is not counted.
- Latency:
  - A push at edge t into an empty FIFO with the FSM in IDLE gives core_in_valid high in the cycle after edge t+1.
  - Completion at edge c allows the next core_in_valid to start in the cycle after edge c+1. The core is back in IDLE by then.
- core_instr/core_oreg change only on the IDLE->ISSUE edge.
- Counters saturate at all-ones.
- A push into an empty FIFO is never bypassed; it always passes through storage, so there is 1 cycle minimum FIFO residency.
- Reset mid-operation: everything returns to reset values immediately. Entries lost in the FIFO are not reported.

Decomposition:
- mips_pkg holds:
  - INSTR_W=32 and OREG_W=20;
  - entry struct issue_entry_t {oreg, instr};
  - enum issue_state_t {IDLE, ISSUE, WAIT}.
- Sub-module mips_issue_fifo: parameterised sync FIFO on issue_entry_t with push/pop/flush, count, full, empty. The top level holds the FSM, watchdog and counters.

Test Plan:
- Reset, then push instr 0x02324020 with oreg 0x00000 → core_in_valid pulse of exactly 1 cycle, 2 cycles after the push edge, with core_instr=0x02324020. Core model returns out_valid 3 cycles later → issue_cnt=1, fail_cnt=0, busy low.
- Back-to-back pushes of 10 entries with DEPTH=8 and a slow core → host_ready deasserts when count=8. Entries are issued in FIFO order and only one is outstanding at a time. Each next in_valid comes ≥2 cycles after the previous out_valid.
- Core returns core_fail=1 on the 2nd of 3 instructions → fail_cnt=1, issue_cnt=3.
- Core model never responds, TIMEOUT=64 → err_timeout rises 64 cycles after entering WAIT. The FSM issues the next queued entry and err_timeout stays 1.
- flush asserted with 5 entries queued, one in flight, and a same-cycle host push → count=0 and the pushed entry is dropped. The in-flight completion is still counted and no further issues occur.
- rst_n asserted mid-WAIT with 3 entries queued → all outputs return to reset values asynchronously. After release, host_ready=1 and no in_valid occurs without new pushes.
